cn_mem_reader: RTL
==================

Name: cn_mem_reader

Overview:
- Read-back engine for the cn_top scratchpad. It is the reader counterpart of the host-side loader that writes h0, code and memory through the Avalon slave ports.
- After the main loop reports finished, it walks a programmable address range through the 128-bit mem slave port. Each word read is presented on a valid/ready output stream for result extraction or comparison.
- It sits between cn_top's mem interface and a host DMA or checker.

Parameters:
- ADDRESS_WIDTH, 15, matches cn_top. The mem address is ADDRESS_WIDTH+2 bits wide.
- READ_LATENCY, 1, fixed number of cycles from mem_read/mem_address to valid mem_rddata (1..3).
- FIFO_DEPTH, 4, output buffer depth in words. Must be ≥ READ_LATENCY+1 and a power of 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request. Accepted only in IDLE.
- wait_finished  in  1  sampled with start. 1 = wait for a rising edge of sts_ml_finished before reading.
- base_addr  in  ADDRESS_WIDTH+2  first word address, sampled with start
- word_count  in  ADDRESS_WIDTH+3  number of 128-bit words, sampled with start. 0 is legal.
- sts_ml_finished  in  1  from cn_top
- mem_address  out  ADDRESS_WIDTH+2  read address to cn_top
- mem_read  out  1  read strobe, one word per asserted cycle
- mem_rddata  in  128  read data, valid READ_LATENCY cycles after mem_read
- out_data  out  128  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  marks the final word of the transfer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset values: all outputs 0. State is IDLE. FIFO is empty, in-flight pipe is cleared, and counters are 0.
- Reset mid-operation: any in-flight read data is discarded, the FIFO is flushed, no done pulse is generated, and the next state is IDLE.
- States:
  - IDLE: on start, latch base, count and wait_finished. If count = 0, go to DONE. Else if wait_finished = 1, go to ARM. Else go to READ. A start outside IDLE is ignored.
  - ARM: sts_ml_finished is registered for edge detection. The first 0→1 transition seen after entering ARM moves to READ. A level already high on entry does not count.
  - READ: issue one read per cycle when issued < count AND fifo_count + inflight < FIFO_DEPTH.
    - mem_address = base + issued, truncated to ADDRESS_WIDTH+2 bits, so it wraps modulo 2^(ADDRESS_WIDTH+2).
    - mem_address holds its last value when mem_read = 0.
    - When issued = count, go to DRAIN. This happens the same cycle as the last issue takes effect.
  - DRAIN: stay until inflight = 0, the FIFO is empty, and the final word has handshaken. Then go to DONE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE. busy drops in the IDLE cycle.
- In-flight tracking:
  - A READ_LATENCY-deep shift register carries the mem_read tag.
  - A tag exiting the register writes mem_rddata into the FIFO that cycle.
  - The credit rule above guarantees the FIFO never overflows, so no data is dropped.
- Output stream:
  - First-word-fall-through. out_data/out_valid come from the FIFO head.
  - A transfer occurs when out_valid & out_ready. out_data is stable while out_valid & !out_ready.
  - out_last = 1 with the head word whose sequence index = count-1. A separate delivered counter is compared against count.
- Throughput: with out_ready held at 1, one word per cycle sustained. First out_valid appears READ_LATENCY+1 cycles after entering READ.
- Simultaneous FIFO push and pop in the same cycle is allowed and leaves the count unchanged.
- The byte/word order of mem_rddata is passed through unchanged.

Decomposition:
- Package cn_pkg holds:
  - state encoding constants (IDLE, ARM, READ, DRAIN, DONE)
  - MEM_DATA_W = 128
  - address width derivation from ADDRESS_WIDTH
- Sub-module cn_rd_fifo: synchronous FWFT FIFO, parameterised width/depth, with count output. It is shared with future stream blocks.

Test Plan:
- Memory preloaded with word k = {k+1, k} (64-bit halves). start, base = 0, count = 8, wait_finished = 0, out_ready = 1 → 8 words {1,0}…{8,7} on consecutive cycles, out_last on the 8th, one done pulse, busy low afterwards.
- count = 16, out_ready toggled 1-0-0-1 pseudo-randomly → all 16 words in order, no duplicates or losses, out_data stable while stalled, mem_read never issued with fifo_count + inflight = 4.
- base = 0x1FFFE, count = 4 → addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 read and delivered in that order.
- wait_finished = 1 with sts_ml_finished held low 100 cycles, then rising → no mem_read before the edge, first read within 2 cycles after it. Repeat with sts_ml_finished already high at start → remains in ARM until low→high.
- count = 0 → no mem_read, no out_valid, done pulse 2 cycles after start. A second start while busy (count = 32 run) → ignored, exactly 32 words delivered.
- reset asserted mid-READ after 5 of 32 words → all outputs 0 the next cycle, no done. A new start, base = 0, count = 2 → clean 2-word transfer.

Source files
------------

// File: rtl/cn_pkg.sv
// Shared types and width helpers for the cn scratchpad read-back path.
package cn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int MEM_DATA_W = 128;

  function automatic int mem_addr_w(input int address_width);
    return address_width + 2;
  endfunction

  function automatic int word_cnt_w(input int address_width);
    return address_width + 3;
  endfunction

endpackage

// File: rtl/cn_mem_reader_if.sv
// Memory read port and output stream between the reader and its environment.
interface cn_mem_reader_if import cn_pkg::*; #(
  parameter int ADDRESS_WIDTH = 15
) ();

  logic [mem_addr_w(ADDRESS_WIDTH)-1:0] mem_address;
  logic                                 mem_read;
  logic [MEM_DATA_W-1:0]                mem_rddata;
  logic [MEM_DATA_W-1:0]                out_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 out_last;

  modport master (
    output mem_address, mem_read, out_data, out_valid, out_last,
    input  mem_rddata, out_ready
  );

  modport slave (
    input  mem_address, mem_read, out_data, out_valid, out_last,
    output mem_rddata, out_ready
  );

endinterface

// File: rtl/cn_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module cn_rd_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && (count_r < FULL_COUNT);
  assign pop_ok_s  = pop && (count_r != '0);
  assign valid     = (count_r != '0);
  // An empty FIFO presents zero rather than stale storage.
  assign pop_data  = (count_r != '0) ? mem_r[rd_ptr_r] : '0;
  assign count     = count_r;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Data storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/cn_mem_reader.sv
// Walks an address range of the cn_top scratchpad after the main loop finishes
// and streams each 128-bit word out through a small FWFT buffer.
module cn_mem_reader import cn_pkg::*; #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int READ_LATENCY  = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 wait_finished,
  input  logic [mem_addr_w(ADDRESS_WIDTH)-1:0] base_addr,
  input  logic [word_cnt_w(ADDRESS_WIDTH)-1:0] word_count,
  input  logic                                 sts_ml_finished,
  output logic                                 busy,
  output logic                                 done,
  cn_mem_reader_if.master                      bus
);

  localparam int AW   = mem_addr_w(ADDRESS_WIDTH);
  localparam int CW   = word_cnt_w(ADDRESS_WIDTH);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  state_t                state_r;
  state_t                next_state_s;
  logic [AW-1:0]         base_r;
  logic [AW-1:0]         mem_address_r;
  logic [AW-1:0]         issue_addr_s;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         issued_r;
  logic [CW-1:0]         delivered_r;
  logic [READ_LATENCY-1:0] pipe_r;
  logic                  mem_read_r;
  logic                  sts_prev_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  issue_s;
  logic                  rise_s;
  logic                  credit_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_valid_s;
  logic [CNTW-1:0]       fifo_count_s;
  logic [MEM_DATA_W-1:0] fifo_data_s;
  logic [7:0]            inflight_s;
  logic [7:0]            credit_sum_s;

  cn_rd_fifo #(
    .WIDTH (MEM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (bus.mem_rddata),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .valid     (fifo_valid_s),
    .count     (fifo_count_s)
  );

  assign push_s = pipe_r[READ_LATENCY-1];
  assign pop_s  = fifo_valid_s & bus.out_ready;
  assign rise_s = sts_ml_finished & ~sts_prev_r;

  // Reads not yet in the FIFO, and whether one more fits once this cycle's pop leaves.
  always_comb begin
    inflight_s = 8'(mem_read_r);
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_s = inflight_s + 8'(pipe_r[i]);
    end
    credit_sum_s = 8'(fifo_count_s) + inflight_s - 8'(pop_s);
    credit_s     = (credit_sum_s < 8'(FIFO_DEPTH));
  end

  // Next state and read issue; the first read goes out on the edge that leaves IDLE/ARM.
  always_comb begin
    next_state_s = state_r;
    issue_s      = 1'b0;
    issue_addr_s = mem_address_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            next_state_s = ST_DONE;
          end else if (wait_finished) begin
            next_state_s = ST_ARM;
          end else begin
            issue_s      = 1'b1;
            issue_addr_s = base_addr;
            next_state_s = (word_count == CW'(1)) ? ST_DRAIN : ST_READ;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (rise_s) begin
          issue_s      = 1'b1;
          issue_addr_s = base_r;
          next_state_s = (count_r == CW'(1)) ? ST_DRAIN : ST_READ;
        end else begin
          next_state_s = ST_ARM;
        end
      end
      ST_READ: begin
        if (issued_r < count_r) begin
          if (credit_s) begin
            issue_s      = 1'b1;
            issue_addr_s = base_r + issued_r[AW-1:0];
            next_state_s = (issued_r + CW'(1) == count_r) ? ST_DRAIN : ST_READ;
          end else begin
            next_state_s = ST_READ;
          end
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((inflight_s == 8'd0) && !fifo_valid_s && (delivered_r == count_r)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, transfer counters, latency tag pipe and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      base_r        <= '0;
      count_r       <= '0;
      issued_r      <= '0;
      delivered_r   <= '0;
      pipe_r        <= '0;
      mem_read_r    <= 1'b0;
      mem_address_r <= '0;
      sts_prev_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      sts_prev_r <= sts_ml_finished;
      mem_read_r <= issue_s;
      busy_r     <= (next_state_s != ST_IDLE);
      done_r     <= (state_r == ST_DONE);
      if (issue_s) begin
        mem_address_r <= issue_addr_s;
      end
      pipe_r[0] <= mem_read_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      if ((state_r == ST_IDLE) && start) begin
        base_r      <= base_addr;
        count_r     <= word_count;
        issued_r    <= CW'(issue_s);
        delivered_r <= '0;
      end else begin
        if (issue_s) begin
          issued_r <= issued_r + CW'(1);
        end
        if (pop_s) begin
          delivered_r <= delivered_r + CW'(1);
        end
      end
    end
  end

  assign bus.mem_address = mem_address_r;
  assign bus.mem_read    = mem_read_r;
  assign bus.out_data    = fifo_data_s;
  assign bus.out_valid   = fifo_valid_s;
  assign bus.out_last    = fifo_valid_s && (delivered_r == count_r - CW'(1));
  assign busy            = busy_r;
  assign done            = done_r;

endmodule
